// File: rtl/fp_dot_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// fp_dot_accum_ctrl_if
// Groups the stream, adder and result signals of the dot-product sequencer.
//   start/vec_len        : run request and element count
//   in_valid/in_data     : product stream in; in_ready back to the producer
//   add_a/add_b          : operands to the shared combinational float adder
//   add_result           : adder sum returned to the sequencer
//   busy/done/sum        : run status and final dot-product result
//   elem_cnt             : elements accepted in the current run
// master: the environment (multiplier stage, adder, consumer).
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface fp_dot_accum_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic             busy;
  logic             done;
  logic [31:0]      sum;
  logic [LEN_W-1:0] elem_cnt;

  modport master (
    output start, vec_len, in_valid, in_data, add_result,
    input  in_ready, add_a, add_b, busy, done, sum, elem_cnt
  );

  modport slave (
    input  start, vec_len, in_valid, in_data, add_result,
    output in_ready, add_a, add_b, busy, done, sum, elem_cnt
  );
endinterface

// File: rtl/fp_dot_accum_ctrl.sv
// ---------------------------------------------------------------------------
// fp_dot_accum_ctrl
// Streams float32 products into an external combinational float adder and
// accumulates them into a dot-product sum over a programmed vector length.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : fp_dot_accum_ctrl_if.slave (stream in, adder operands/result,
//         busy/done/sum/elem_cnt status)
// The adder assumes an implied leading 1, so zero operands never reach it:
// zero products are skipped, and a zero accumulator is replaced by the
// incoming product instead of being added to it.
// ---------------------------------------------------------------------------
module fp_dot_accum_ctrl #(
  parameter int LEN_W = 8
) (
  input logic                clk,
  input logic                rst,
  fp_dot_accum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q;
  logic [31:0]      sum_q;
  logic             acc_empty_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;

  logic             xfer;
  logic             last;
  logic             in_zero;
  logic             acc_zero;
  logic [31:0]      acc_new;

  // Sign bit ignored: +0 and -0 are both zeros for the adder's purposes.
  assign in_zero  = (bus.in_data[30:0] == 31'd0);
  assign acc_zero = (acc_q[30:0] == 31'd0);
  assign last     = (cnt_q == len_q - LEN_W'(1));

  // Accumulator candidate for this transfer: skip zeros, bypass-load into an
  // empty or cancelled accumulator, otherwise take the adder sum.
  always_comb begin
    if (in_zero)                      acc_new = acc_q;
    else if (acc_empty_q || acc_zero) acc_new = bus.in_data;
    else                              acc_new = bus.add_result;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.vec_len == '0) ? FINISH : ACCUM;
      end
      ACCUM: begin
        if (bus.in_valid) begin
          xfer = 1'b1;
          if (last) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= 32'h0;
      acc_empty_q <= 1'b1;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= 32'h0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        if (bus.vec_len != '0) begin
          len_q       <= bus.vec_len;
          acc_q       <= 32'h0;
          acc_empty_q <= 1'b1;
          cnt_q       <= '0;
        end else begin
          sum_q <= 32'h0;
        end
      end
      if (xfer) begin
        cnt_q <= cnt_q + LEN_W'(1);
        if (!in_zero) begin
          acc_q       <= acc_new;
          acc_empty_q <= 1'b0;
        end
        if (last) sum_q <= acc_new;
      end
    end
  end

  // in_ready depends on state only so the producer never sees a
  // combinational path from its own valid.
  assign bus.in_ready = (state_q == ACCUM);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FINISH);
  assign bus.add_a    = acc_q;
  assign bus.add_b    = bus.in_data;
  assign bus.sum      = sum_q;
  assign bus.elem_cnt = cnt_q;

endmodule
